ifu_prefetch: RTL

Parametrised instruction-fetch stage with a decoupling instruction queue. It fetches 64-bit aligned blocks from the instruction bus and splits each block into one or two 32-bit instructions. It buffers the instructions with their PCs and fault flags, and hands them to decode over a valid/ready handshake. It sits between the pipeline redirect logic (branch/exception), the instruction bus port and the decode stage. It replaces the single-instruction, stall-vector-driven fetch.

---
 rtl/ifu_prefetch_pkg.sv | 22 ++
 rtl/ifu_prefetch_if.sv | 42 ++++
 rtl/ifu_inst_fifo.sv | 54 +++++
 rtl/ifu_prefetch.sv | 118 +++++++++++
 4 files changed

// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch stage.
// Queue entries carry a full 64-bit PC slot regardless of XLEN.
package ifu_prefetch_pkg;

  localparam logic [1:0] SIZE_D    = 2'b11;
  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int          PC_W         = 64;
  localparam logic [63:0] PC_START_DEF = 64'h8000_0000;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     inst;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_prefetch_if.sv
// Instruction-bus and decode-side handshake bundles for the fetch stage.
// The fetch stage is master on both; bus agent and decode are slaves.
interface ifu_bus_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_addr;
  logic [1:0]      if_size;
  logic [63:0]     if_data_read;
  logic [1:0]      if_resp;

  modport master (
    output if_valid, if_addr, if_size,
    input  if_ready, if_data_read, if_resp
  );

  modport slave (
    input  if_valid, if_addr, if_size,
    output if_ready, if_data_read, if_resp
  );
endinterface

interface ifu_inst_if #(
  parameter int XLEN = 64
);
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_fault;

  modport master (
    output inst_valid, inst, inst_pc, inst_fault,
    input  inst_ready
  );

  modport slave (
    input  inst_valid, inst, inst_pc, inst_fault,
    output inst_ready
  );
endinterface

// File: rtl/ifu_inst_fifo.sv
// Instruction queue: up to two in-order writes and one read per cycle.
// Flush empties it; the head reads as zero while empty.
module ifu_inst_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en0,
  input  logic         wr_en1,
  input  fetch_entry_t wr_data0,
  input  fetch_entry_t wr_data1,
  input  logic         rd_en,
  output fetch_entry_t rd_data,
  output logic         valid,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] n_wr;
  logic          do_rd;

  assign valid   = count != '0;
  assign do_rd   = rd_en & valid;
  assign n_wr    = CW'(wr_en0) + CW'(wr_en1);
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_wr);
      rd_ptr <= rd_ptr + AW'(do_rd);
      count  <= count + n_wr - CW'(do_rd);
    end
  end

  // second write lands behind the first when both fire
  always_ff @(posedge clk) begin
    if (wr_en0)
      mem[wr_ptr] <= wr_data0;
    if (wr_en1)
      mem[wr_en0 ? wr_ptr + AW'(1) : wr_ptr] <= wr_data1;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Fetch stage: 64-bit block fetch, split into 32-bit instructions,
// buffered in a flushable queue towards decode.
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_START = XLEN'(PC_START_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  ifu_bus_if.master       bus,
  ifu_inst_if.master      dec
);

  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   FILL_MAX = CW'(DEPTH - 2);
  localparam logic [XLEN-1:0] ALIGN8   = ~XLEN'(7);
  localparam logic [XLEN-1:0] ALIGN4   = ~XLEN'(3);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            req_q, req_d;
  logic            drop_q, drop_d;
  logic            fire, hold, take, ok, hi, deq;
  logic            wr_en0, wr_en1, head_valid;
  fetch_entry_t    wr_data0, wr_data1, head;
  logic [CW-1:0]   count, count_d;
  logic [31:0]     lo_word, hi_word;

  assign lo_word = bus.if_data_read[31:0];
  assign hi_word = bus.if_data_read[63:32];

  always_comb begin
    fire     = req_q & bus.if_ready;
    hold     = req_q & ~bus.if_ready;
    take     = fire & ~drop_q & ~redirect_valid;
    ok       = bus.if_resp == RESP_OKAY;
    hi       = fetch_pc_q[2];
    deq      = head_valid & dec.inst_ready;
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q & ~fire;
    wr_en0   = take;
    wr_en1   = take & ok & ~hi;
    wr_data0 = '{pc: PC_W'(fetch_pc_q),
                 inst: hi ? hi_word : lo_word,
                 fault: 1'b0};
    wr_data1 = '{pc: PC_W'(fetch_pc_q + XLEN'(4)),
                 inst: hi_word,
                 fault: 1'b0};
    unique case (1'b1)
      take && ok: fetch_pc_d = addr_q + XLEN'(8);
      take && !ok: begin
        wr_data0 = '{pc: PC_W'(fetch_pc_q),
                     inst: 32'h0,
                     fault: 1'b1};
        state_d  = ST_HALT;
      end
      default: ;
    endcase
    // an in-flight beat survives a redirect but its data is dropped
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN4;
      state_d    = ST_FETCH;
      drop_d     = drop_d | hold;
    end
    count_d = redirect_valid ? '0
            : count + CW'(wr_en0) + CW'(wr_en1) - CW'(deq);
    req_d  = hold |
             (state_d == ST_FETCH && count_d <= FILL_MAX);
    addr_d = hold ? addr_q : (fetch_pc_d & ALIGN8);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= PC_START;
      addr_q     <= PC_START & ALIGN8;
      req_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      drop_q     <= drop_d;
    end
  end

  ifu_inst_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_valid),
    .wr_en0  (wr_en0),
    .wr_en1  (wr_en1),
    .wr_data0(wr_data0),
    .wr_data1(wr_data1),
    .rd_en   (deq),
    .rd_data (head),
    .valid   (head_valid),
    .count   (count)
  );

  assign bus.if_valid   = req_q;
  assign bus.if_addr    = addr_q;
  assign bus.if_size    = SIZE_D;
  assign dec.inst_valid = head_valid;
  assign dec.inst       = head.inst;
  assign dec.inst_pc    = head.pc[XLEN-1:0];
  assign dec.inst_fault = head.fault;

endmodule
